// File: rtl/r200_pkg.sv
// Shared types and helpers for the r200 hazard controller.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package r200_pkg;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Widest register address a shadow entry can carry; narrower AW values
    // are zero-extended into this field.
    localparam int HZD_RD_W = 8;

    typedef struct packed {
        logic                valid;
        logic [HZD_RD_W-1:0] rd;
        logic                regwr;
        logic                isload;
    } hzd_entry_t;

    // Width of a forwarding select that encodes RF plus nfwd stages.
    function automatic int fwd_sel_w(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/r200_hazard_ctrl_if.sv
// ID-side hazard interface: instruction fields and redirect in, controls and counters out.
// Latency: plain wires, no storage.
// Backpressure: stall/bubble returned to the pipeline; the master honours them.
interface r200_hazard_ctrl_if
    import r200_pkg::*;
#(
    parameter int NFWD = 3,
    parameter int AW   = 5,
    parameter int CNTW = 32
);
    localparam int SW = fwd_sel_w(NFWD);

    logic            id_valid;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_rs1_use;
    logic            id_rs2_use;
    logic [AW-1:0]   id_rd;
    logic            id_regwr;
    logic            id_isload;
    logic            ex_redirect;
    logic            stall;
    logic            flush;
    logic            bubble;
    logic [SW-1:0]   rs1_fwd;
    logic [SW-1:0]   rs2_fwd;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    // Pipeline side: drives the ID instruction and the EX redirect.
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
               id_rd, id_regwr, id_isload, ex_redirect,
        input  stall, flush, bubble, rs1_fwd, rs2_fwd, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use,
               id_rd, id_regwr, id_isload, ex_redirect,
        output stall, flush, bubble, rs1_fwd, rs2_fwd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/r200_hzd_shadow.sv
// Shadow pipeline of destination tags, one entry per stage after ID (0 = EX).
// Latency: 1 cycle per stage; entry 0 is loaded from i_ins on each posedge.
// Backpressure: none; i_ins_vld low inserts an invalid (bubble) entry.
// Ports: clk, rst (async, active-high), i_ins_vld/i_ins (entry-0 insert), o_ent (all entries).
module r200_hzd_shadow
    import r200_pkg::*;
#(
    parameter int NFWD = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ins_vld,
    input  hzd_entry_t            i_ins,
    output hzd_entry_t [NFWD-1:0] o_ent
);

    hzd_entry_t [NFWD-1:0] r_ent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent <= '0;
        end else begin
            r_ent[0] <= i_ins_vld ? i_ins : '0;
            // Older stages shift one step; the last (WB) entry simply retires.
            for (int k = 1; k < NFWD; k++) begin
                r_ent[k] <= r_ent[k-1];
            end
        end
    end

    assign o_ent = r_ent;

endmodule

// File: rtl/r200_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, redirect flush/bubble, event counters.
// Latency: controls are combinational (0 cycles) from inputs and the registered shadow.
// Backpressure: stall holds PC and IF/ID; bubble injects a NOP into ID/EX.
// Ports: clk, rst (async, active-high), hz (slave side of r200_hazard_ctrl_if).
// AW must not exceed r200_pkg::HZD_RD_W; LOAD_STAGE must lie in [0, NFWD).
module r200_hazard_ctrl
    import r200_pkg::*;
#(
    parameter int NFWD       = 3,
    parameter int AW         = 5,
    parameter int LOAD_STAGE = 2,
    parameter int CNTW       = 32
) (
    input  logic               clk,
    input  logic               rst,
    r200_hazard_ctrl_if.slave  hz
);

    localparam int SW = fwd_sel_w(NFWD);

    hzd_entry_t [NFWD-1:0] w_shadow;
    hzd_entry_t            w_ins;
    logic                  w_ins_vld;
    logic [SW-1:0]         w_rs1_sel;
    logic [SW-1:0]         w_rs2_sel;
    logic                  w_rs1_lu;
    logic                  w_rs2_lu;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_flush;
    logic                  w_bubble;
    logic [CNTW-1:0]       r_stall_cnt;
    logic [CNTW-1:0]       r_flush_cnt;

    // Youngest matching producer wins: scan oldest to youngest so the lowest
    // index overwrites. x0 never forwards, so a zero source stays on the RF.
    function automatic logic [SW-1:0] fwd_pick(
        input hzd_entry_t [NFWD-1:0] ent,
        input logic [AW-1:0]         src,
        input logic                  src_use
    );
        logic [SW-1:0] sel;
        sel = SW'(FWD_RF);
        if (src_use && (src != '0)) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (ent[k].valid && ent[k].regwr && (ent[k].rd == HZD_RD_W'(src))) begin
                    sel = SW'(k + 1);
                end
            end
        end
        return sel;
    endfunction

    // The winning producer is a load whose data is not yet forwardable.
    function automatic logic load_use(
        input hzd_entry_t [NFWD-1:0] ent,
        input logic [SW-1:0]         sel
    );
        logic lu;
        lu = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if ((sel == SW'(k + 1)) && ent[k].isload && (k < LOAD_STAGE)) begin
                lu = 1'b1;
            end
        end
        return lu;
    endfunction

    always_comb begin
        w_rs1_sel = fwd_pick(w_shadow, hz.id_rs1, hz.id_rs1_use);
        w_rs2_sel = fwd_pick(w_shadow, hz.id_rs2, hz.id_rs2_use);
        w_rs1_lu  = load_use(w_shadow, w_rs1_sel);
        w_rs2_lu  = load_use(w_shadow, w_rs2_sel);
        w_hazard  = w_rs1_lu | w_rs2_lu;
        // A redirect squashes the ID instruction, so it must not also stall.
        w_stall   = hz.id_valid & w_hazard & ~hz.ex_redirect;
        w_flush   = hz.ex_redirect;
        w_bubble  = w_stall | hz.ex_redirect;
        w_ins_vld = hz.id_valid & ~w_bubble;
        w_ins     = '{valid:  1'b1,
                      rd:     HZD_RD_W'(hz.id_rd),
                      regwr:  hz.id_regwr,
                      isload: hz.id_isload};
    end

    r200_hzd_shadow #(
        .NFWD (NFWD)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .i_ins_vld (w_ins_vld),
        .i_ins     (w_ins),
        .o_ent     (w_shadow)
    );

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (w_flush && (r_flush_cnt != {CNTW{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    assign hz.stall     = w_stall;
    assign hz.flush     = w_flush;
    assign hz.bubble    = w_bubble;
    assign hz.rs1_fwd   = w_rs1_sel;
    assign hz.rs2_fwd   = w_rs2_sel;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_r200_hazard_ctrl.sv
// Bench for r200_hazard_ctrl: directed ID/redirect vectors, expected controls queued per cycle.
// Latency: expectations are sampled on the falling edge of the cycle they were issued in.
// Backpressure: n/a (bench drives the ID stage directly).
module tb_r200_hazard_ctrl;

    logic clk;
    logic rst;
    logic mid_smp;

    int checks;
    int errors;

    r200_hazard_ctrl_if #(.NFWD(3), .AW(5), .CNTW(4)) hif ();

    r200_hazard_ctrl #(
        .NFWD       (3),
        .AW         (5),
        .LOAD_STAGE (2),
        .CNTW       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {stall, flush, bubble, rs1_fwd[1:0], rs2_fwd[1:0], stall_cnt[3:0], flush_cnt[3:0]}
    logic [14:0] exp_q[$];
    string       nm_q[$];
    logic [14:0] m_exp;
    logic [14:0] m_act;
    string       m_nm;

    task automatic push_exp(input string nm, input logic st, input logic fl, input logic bu,
                            input logic [1:0] r1, input logic [1:0] r2,
                            input logic [3:0] sc, input logic [3:0] fc);
        exp_q.push_back({st, fl, bu, r1, r2, sc, fc});
        nm_q.push_back(nm);
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic redir);
        hif.id_valid    = v;
        hif.id_rs1      = s1;
        hif.id_rs1_use  = u1;
        hif.id_rs2      = s2;
        hif.id_rs2_use  = u2;
        hif.id_rd       = rd;
        hif.id_regwr    = wr;
        hif.id_isload   = ld;
        hif.ex_redirect = redir;
    endtask

    // Drive one ID cycle, queue its expected outputs, advance to the next cycle.
    task automatic step(input string nm, input logic v, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic redir,
                        input logic st, input logic fl, input logic bu,
                        input logic [1:0] r1, input logic [1:0] r2,
                        input logic [3:0] sc, input logic [3:0] fc);
        drive(v, s1, u1, s2, u2, rd, wr, ld, redir);
        push_exp(nm, st, fl, bu, r1, r2, sc, fc);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever is queued whenever the outputs are sampled.
    always @(negedge clk or posedge mid_smp) begin
        if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            m_nm  = nm_q.pop_front();
            m_act = {hif.stall, hif.flush, hif.bubble, hif.rs1_fwd, hif.rs2_fwd,
                     hif.stall_cnt, hif.flush_cnt};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got st/fl/bu=%b%b%b fwd1=%0d fwd2=%0d scnt=%0d fcnt=%0d; want st/fl/bu=%b%b%b fwd1=%0d fwd2=%0d scnt=%0d fcnt=%0d",
                         m_nm, m_act[14], m_act[13], m_act[12], m_act[11:10], m_act[9:8],
                         m_act[7:4], m_act[3:0], m_exp[14], m_exp[13], m_exp[12],
                         m_exp[11:10], m_exp[9:8], m_exp[7:4], m_exp[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1);
    end

    int       nst;
    int       ph;
    logic     est;
    logic [1:0] esel;

    initial begin
        checks  = 0;
        errors  = 0;
        mid_smp = 1'b0;
        rst     = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        //    name            v  rs1 u1 rs2 u2 rd wr ld rd  st fl bu r1 r2 sc fc
        step("reset",         0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        // ALU chain on x5
        step("alu_prod",      1, 0,  0, 0,  0, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("alu_fwd_ex",    1, 5,  1, 0,  0, 6, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        step("alu_fwd_mem",   1, 5,  1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0);
        step("alu_fwd_wb",    1, 6,  1, 5,  1, 0, 0, 0, 0,  0, 0, 0, 2, 3, 0, 0);
        // Load-use on x7 via rs2
        step("lw_issue",      1, 6,  1, 0,  0, 7, 1, 1, 0,  0, 0, 0, 3, 0, 0, 0);
        step("lu_stall1",     1, 0,  0, 7,  1, 8, 1, 0, 0,  1, 0, 1, 0, 1, 0, 0);
        step("lu_stall2",     1, 0,  0, 7,  1, 8, 1, 0, 0,  1, 0, 1, 0, 2, 1, 0);
        step("lu_release",    1, 0,  0, 7,  1, 8, 1, 0, 0,  0, 0, 0, 0, 3, 2, 0);
        // x0 producer and unused sources
        step("x0_prod_unused",1, 8,  0, 0,  0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 2, 0);
        step("x0_src",        1, 0,  1, 8,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0);
        // Redirect while a load-use hazard is present
        step("lw9_issue",     1, 0,  0, 0,  0, 9, 1, 1, 0,  0, 0, 0, 0, 0, 2, 0);
        step("redir_lu",      1, 9,  1, 0,  0,10, 1, 0, 1,  0, 1, 1, 1, 0, 2, 0);
        step("redir_after",   1,10,  1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        // Three producers of x3
        step("x3_a",          1, 0,  0, 0,  0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        step("x3_b",          1, 0,  0, 0,  0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        step("x3_c",          1, 0,  0, 0,  0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        step("x3_both",       1, 3,  1, 3,  1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 2, 1);
        step("x3_rs2",        1, 0,  0, 3,  1, 0, 0, 0, 0,  0, 0, 0, 0, 2, 2, 1);
        // Reset in the middle of a load-use stall
        step("lw7b_issue",    1, 0,  0, 0,  0, 7, 1, 1, 0,  0, 0, 0, 0, 0, 2, 1);
        step("rst_lu1",       1, 7,  1, 0,  0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 2, 1);
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        push_exp("rst_lu2", 1, 0, 1, 2, 0, 3, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        push_exp("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        #2;
        mid_smp = 1'b1;
        #1;
        mid_smp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst",      0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Self-dependent load held in ID: stall, stall, issue, repeating.
        nst = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                est  = 1'b0;
                esel = 2'd0;
            end else begin
                ph   = (i - 1) % 3;
                est  = (ph != 2);
                esel = 2'(ph + 1);
            end
            step($sformatf("sat%0d", i), 1, 7, 1, 0, 0, 7, 1, 1, 0,
                 est, 0, est, esel, 0, 4'((nst > 15) ? 15 : nst), 0);
            if (est) nst++;
        end
        step("sat_hold",      0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,15, 0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
